// File: rtl/rv32_instr_injector_pkg.sv
// Shared RV32 types for the instruction injector: instruction word, request opcodes,
// base opcodes and small format helpers used by the encoder.
package rv32_instr_injector_pkg;

    typedef logic [31:0] rv_instr_t;

    typedef enum logic [2:0] {
        ENC_NOP   = 3'd0,
        ENC_LUI   = 3'd1,
        ENC_AUIPC = 3'd2,
        ENC_JAL   = 3'd3,
        ENC_ADDI  = 3'd4,
        ENC_ADD   = 3'd5,
        ENC_SW    = 3'd6,
        ENC_LI    = 3'd7
    } enc_op_t;

    typedef enum logic {
        IDLE,
        EMIT_LO
    } inj_state_t;

    localparam int FIFO_DEPTH = 4;

    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam rv_instr_t NOP_INSTR = 32'h0000_0013;

    function automatic rv_instr_t enc_u(input logic [19:0] imm20, input logic [4:0] rd,
                                        input logic [6:0] opc);
        return {imm20, rd, opc};
    endfunction

    function automatic rv_instr_t enc_addi(input logic [11:0] imm12, input logic [4:0] rs1,
                                           input logic [4:0] rd);
        return {imm12, rs1, 3'b000, rd, OPC_OPIMM};
    endfunction

    function automatic rv_instr_t enc_add(input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [4:0] rd);
        return {7'b0000000, rs2, rs1, 3'b000, rd, OPC_OP};
    endfunction

    function automatic rv_instr_t enc_sw(input logic [11:0] imm12, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
        return {imm12[11:5], rs2, rs1, 3'b010, imm12[4:0], OPC_STORE};
    endfunction

    // J-format scatters the halfword offset; bit 0 is implicit and checked by the caller.
    function automatic rv_instr_t enc_jal(input logic [20:1] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/rv32_instr_fifo.sv
// Registered show-ahead FIFO for 32-bit instruction words; the head entry is visible
// on data_o the cycle after it is written.
module rv32_instr_fifo
    import rv32_instr_injector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push_i,
    input  logic [31:0]                  data_i,
    input  logic                         pop_i,
    output logic [31:0]                  data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped even if a pop happens in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rv32_instr_injector.sv
// Turns high-level instruction requests into RV32I words (LI may expand into LUI+ADDI)
// and buffers them in a small FIFO toward the consumer.
module rv32_instr_injector
    import rv32_instr_injector_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [31:0] req_imm,
    output logic        instr_valid,
    input  logic        instr_ready,
    output rv_instr_t   instr,
    output logic [2:0]  fifo_count,
    output logic        busy,
    output logic        err_invalid
);

    inj_state_t  state_q, state_d;
    logic [4:0]  lo_rd_q, lo_rd_d;
    logic [11:0] lo_imm_q, lo_imm_d;
    logic        err_q, err_d;

    enc_op_t     op;
    logic        accept;
    logic        push;
    rv_instr_t   push_data;
    logic        fifo_full, fifo_empty;
    rv_instr_t   fifo_data;
    logic        li_fits12;
    logic [19:0] li_upper;

    assign op        = enc_op_t'(req_op);
    assign req_ready = !rst && (state_q == IDLE) && !fifo_full;
    assign accept    = req_valid && req_ready;

    // Rounding the upper part by imm[11] compensates for ADDI sign-extending its immediate.
    assign li_fits12 = (req_imm[31:11] == {21{req_imm[11]}});
    assign li_upper  = req_imm[31:12] + {19'b0, req_imm[11]};

    always_comb begin
        state_d   = state_q;
        lo_rd_d   = lo_rd_q;
        lo_imm_d  = lo_imm_q;
        err_d     = 1'b0;
        push      = 1'b0;
        push_data = NOP_INSTR;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    push = 1'b1;
                    case (op)
                        ENC_NOP:   push_data = NOP_INSTR;
                        ENC_LUI:   push_data = enc_u(req_imm[31:12], req_rd, OPC_LUI);
                        ENC_AUIPC: push_data = enc_u(req_imm[31:12], req_rd, OPC_AUIPC);
                        ENC_JAL: begin
                            push_data = enc_jal(req_imm[20:1], req_rd);
                            if (req_imm[0]) begin
                                push  = 1'b0;
                                err_d = 1'b1;
                            end
                        end
                        ENC_ADDI:  push_data = enc_addi(req_imm[11:0], req_rs1, req_rd);
                        ENC_ADD:   push_data = enc_add(req_rs2, req_rs1, req_rd);
                        ENC_SW:    push_data = enc_sw(req_imm[11:0], req_rs2, req_rs1);
                        ENC_LI: begin
                            if (li_fits12) begin
                                push_data = enc_addi(req_imm[11:0], 5'd0, req_rd);
                            end else begin
                                push_data = enc_u(li_upper, req_rd, OPC_LUI);
                                if (req_imm[11:0] != 12'd0) begin
                                    state_d  = EMIT_LO;
                                    lo_rd_d  = req_rd;
                                    lo_imm_d = req_imm[11:0];
                                end
                            end
                        end
                        default: begin
                            push  = 1'b0;
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            EMIT_LO: begin
                if (!fifo_full) begin
                    push      = 1'b1;
                    push_data = enc_addi(lo_imm_q, lo_rd_q, lo_rd_q);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            lo_rd_q  <= '0;
            lo_imm_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_rd_q  <= lo_rd_d;
            lo_imm_q <= lo_imm_d;
            err_q    <= err_d;
        end
    end

    rv32_instr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (instr_valid && instr_ready),
        .data_o  (fifo_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = fifo_empty ? NOP_INSTR : fifo_data;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign err_invalid = err_q;

endmodule

// File: tb/tb_rv32_instr_injector.sv
// Self-checking bench for rv32_instr_injector: directed encoding cases plus a random
// phase compared every cycle against a queue-based reference model.
module tb_rv32_instr_injector;
    import rv32_instr_injector_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [4:0]  req_rs1 = 5'd0;
    logic [4:0]  req_rs2 = 5'd0;
    logic [31:0] req_imm = 32'd0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        err_invalid;

    int checks = 0;
    int errors = 0;
    bit checkEn = 1'b0;

    logic [31:0] expQ[$];
    bit          pendLo = 1'b0;
    logic [31:0] loWord = 32'd0;
    bit          expErr = 1'b0;

    logic [31:0] mW0, mW1;
    int          mN;
    bit          mErr, mPop, mPush;
    logic [31:0] mPushWord;
    int          mSize;

    rv32_instr_injector dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_rd      (req_rd),
        .req_rs1     (req_rs1),
        .req_rs2     (req_rs2),
        .req_imm     (req_imm),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .fifo_count  (fifo_count),
        .busy        (busy),
        .err_invalid (err_invalid)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference encoder: produces the word(s) a request must yield from the ISA field layouts.
    task automatic refEncode(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                             input logic [4:0] rs2, input logic [31:0] imm,
                             output logic [31:0] w0, output logic [31:0] w1, output int n, output bit err);
        int simm;
        logic [31:0] hi;
        w0 = 32'h13; w1 = 32'h13; n = 1; err = 1'b0;
        simm = $signed(imm);
        case (op)
            3'd0: w0 = 32'h0000_0013;
            3'd1: w0 = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37;
            3'd2: w0 = (imm & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h17;
            3'd3: begin
                if (imm[0]) begin
                    err = 1'b1; n = 0;
                end else begin
                    w0 = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                       | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                       | (32'(rd) << 7) | 32'h6F;
                end
            end
            3'd4: w0 = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h13;
            3'd5: w0 = (32'(rs2) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h33;
            3'd6: w0 = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                     | (32'h2 << 12) | ((imm & 32'h1F) << 7) | 32'h23;
            default: begin
                if (simm >= -2048 && simm <= 2047) begin
                    w0 = ((imm & 32'hFFF) << 20) | (32'(rd) << 7) | 32'h13;
                end else begin
                    hi = imm + 32'h800;
                    w0 = (hi & 32'hFFFF_F000) | (32'(rd) << 7) | 32'h37;
                    if ((imm & 32'hFFF) != 0) begin
                        n = 2;
                        w1 = ((imm & 32'hFFF) << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
                    end
                end
            end
        endcase
    endtask

    // Reference model: a queue of expected words plus one pending low-half word for LI.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expQ.delete();
            pendLo = 1'b0;
            expErr = 1'b0;
        end else begin
            mSize  = expQ.size();
            mPop   = (mSize > 0) && instr_ready;
            mPush  = 1'b0;
            expErr = 1'b0;
            mPushWord = 32'h13;
            if (pendLo) begin
                if (mSize < FIFO_DEPTH) begin
                    mPush = 1'b1; mPushWord = loWord; pendLo = 1'b0;
                end
            end else if (req_valid && mSize < FIFO_DEPTH) begin
                refEncode(req_op, req_rd, req_rs1, req_rs2, req_imm, mW0, mW1, mN, mErr);
                if (mErr) begin
                    expErr = 1'b1;
                end else begin
                    mPush = 1'b1; mPushWord = mW0;
                    if (mN == 2) begin
                        pendLo = 1'b1; loWord = mW1;
                    end
                end
            end
            if (mPop)  void'(expQ.pop_front());
            if (mPush) expQ.push_back(mPushWord);
        end
    end

    // Compare process: outputs are all functions of registered state, so check mid-cycle.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("model_instr_valid", {31'b0, instr_valid}, {31'b0, expQ.size() > 0});
            checkOutput("model_instr", instr, (expQ.size() > 0) ? expQ[0] : 32'h13);
            checkOutput("model_fifo_count", {29'b0, fifo_count}, 32'(expQ.size()));
            checkOutput("model_req_ready", {31'b0, req_ready},
                        {31'b0, !rst && !pendLo && expQ.size() < FIFO_DEPTH});
            checkOutput("model_busy", {31'b0, busy}, {31'b0, pendLo || expQ.size() > 0});
            checkOutput("model_err_invalid", {31'b0, err_invalid}, {31'b0, expErr});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [31:0] imm);
        int waitCycles;
        waitCycles = 0;
        req_op = op; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        while (!req_ready && waitCycles < 50) begin
            tick(1);
            waitCycles++;
        end
        if (!req_ready) checkOutput("accept_timeout", {31'b0, req_ready}, 32'd1);
        else tick(1);
        req_valid = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, {31'b0, req_ready}, 32'd0);
        checkOutput({tag, "_instr_valid"}, {31'b0, instr_valid}, 32'd0);
        checkOutput({tag, "_instr"}, instr, 32'h0000_0013);
        checkOutput({tag, "_fifo_count"}, {29'b0, fifo_count}, 32'd0);
        checkOutput({tag, "_busy"}, {31'b0, busy}, 32'd0);
        checkOutput({tag, "_err_invalid"}, {31'b0, err_invalid}, 32'd0);
    endtask

    int          mode;
    logic [31:0] rndImm;

    initial begin
        #1 rst = 1'b1;
        checkEn = 1'b1;
        tick(3);
        checkResetOutputs("reset");
        rst = 1'b0;
        #1;
        checkOutput("ready_after_reset", {31'b0, req_ready}, 32'd1);

        // NOP, ADD and SW words appear one cycle after acceptance.
        instr_ready = 1'b1;
        applyStimulus(ENC_NOP, 5'd0, 5'd0, 5'd0, 32'd0);
        checkOutput("nop_valid", {31'b0, instr_valid}, 32'd1);
        checkOutput("nop_word", instr, 32'h0000_0013);
        applyStimulus(ENC_ADD, 5'd3, 5'd1, 5'd2, 32'hFFFF_FFFF);
        checkOutput("add_word", instr, 32'h0020_81B3);
        applyStimulus(ENC_SW, 5'd0, 5'd1, 5'd2, 32'd8);
        checkOutput("sw_word", instr, 32'h0020_A423);

        // LI with a large immediate splits into LUI then ADDI.
        applyStimulus(ENC_LI, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
        checkOutput("li_lui_word", instr, 32'h1234_62B7);
        checkOutput("li_ready_low", {31'b0, req_ready}, 32'd0);
        checkOutput("li_busy", {31'b0, busy}, 32'd1);
        tick(1);
        checkOutput("li_addi_word", instr, 32'hFFF2_8293);
        tick(3);

        // Fill the FIFO with the consumer stalled.
        instr_ready = 1'b0;
        for (int i = 1; i <= 4; i++) applyStimulus(ENC_ADDI, 5'(i), 5'd0, 5'd0, 32'(i));
        req_op = ENC_ADDI; req_rd = 5'd5; req_rs1 = 5'd0; req_imm = 32'd5;
        req_valid = 1'b1;
        tick(2);
        checkOutput("full_count", {29'b0, fifo_count}, 32'd4);
        checkOutput("full_ready", {31'b0, req_ready}, 32'd0);
        checkOutput("full_head", instr, 32'h0010_0093);
        instr_ready = 1'b1;
        tick(1);
        instr_ready = 1'b0;
        checkOutput("after_pop_count", {29'b0, fifo_count}, 32'd3);
        checkOutput("after_pop_head", instr, 32'h0020_0113);
        tick(1);
        req_valid = 1'b0;
        checkOutput("refill_count", {29'b0, fifo_count}, 32'd4);
        instr_ready = 1'b1;
        tick(6);

        // Misaligned JAL target is rejected.
        applyStimulus(ENC_JAL, 5'd1, 5'd0, 5'd0, 32'h3);
        checkOutput("jal_err_pulse", {31'b0, err_invalid}, 32'd1);
        checkOutput("jal_count", {29'b0, fifo_count}, 32'd0);
        tick(1);
        checkOutput("jal_err_clear", {31'b0, err_invalid}, 32'd0);

        // Random traffic checked against the model each cycle.
        for (int c = 0; c < 800; c++) begin
            req_valid   = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 2) != 0);
            req_op      = 3'($urandom_range(0, 7));
            req_rd      = 5'($urandom);
            req_rs1     = 5'($urandom);
            req_rs2     = 5'($urandom);
            mode        = $urandom_range(0, 3);
            rndImm      = $urandom;
            if (mode == 1) rndImm = 32'($signed(12'($urandom)));
            else if (mode == 2) rndImm = rndImm & 32'hFFFF_F000;
            req_imm = rndImm;
            tick(1);
        end
        req_valid = 1'b0;
        instr_ready = 1'b1;
        tick(8);

        // Reset while LI low half is stalled behind a full FIFO.
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(ENC_ADDI, 5'(i + 8), 5'd1, 5'd0, 32'(i));
        applyStimulus(ENC_LI, 5'd7, 5'd0, 5'd0, 32'h1234_5678);
        checkOutput("midli_count", {29'b0, fifo_count}, 32'd4);
        checkOutput("midli_busy", {31'b0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        checkResetOutputs("async_reset");
        @(posedge clk);
        #1 rst = 1'b0;
        instr_ready = 1'b1;
        tick(5);
        checkOutput("no_addi_after_reset", {31'b0, instr_valid}, 32'd0);
        checkOutput("empty_after_reset", {29'b0, fifo_count}, 32'd0);

        checkEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rv32_instr_injector.md
RV32_INSTR_INJECTOR -- requirements
Module: rv32_instr_injector

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have request ports: req_valid in 1, req_ready out 1, req_op in 3 (enc_op_t), req_rd/req_rs1/req_rs2 in 5 each, req_imm in 32.
REQ-003 SHALL have output ports: instr_valid out 1, instr_ready in 1, instr out 32 (rv_instr_t), fifo_count out 3 (0..4), busy out 1 (FSM not IDLE or fifo_count!=0), err_invalid out 1 (one-cycle pulse).
REQ-004 SHALL define enc_op_t values: ENC_NOP, ENC_LUI, ENC_AUIPC, ENC_JAL, ENC_ADDI, ENC_ADD, ENC_SW, ENC_LI.
REQ-005 SHALL define FIFO_DEPTH = 4.

Function
REQ-006 A request SHALL transfer when req_valid and req_ready are high on a clock edge; an instruction SHALL transfer when instr_valid and instr_ready are high.
REQ-007 req_ready SHALL be high only when state==IDLE and fifo_count<FIFO_DEPTH, computed from registered state; no same-cycle push-on-pop bypass when full.
REQ-008 Encodings: LUI rd,imm[31:12] (0110111); AUIPC (0010111); JAL rd,imm[20:1] J-format (1101111); ADDI rd,rs1,imm[11:0] (0010011, f3=000); ADD rd,rs1,rs2 (0110011, f3=000, f7=0); SW rs2,imm[11:0](rs1) S-format (0100011, f3=010); NOP = 0x00000013.
REQ-009 ENC_LI, imm in signed 12-bit range: SHALL push one word, ADDI rd,x0,imm.
REQ-010 ENC_LI, otherwise: SHALL push LUI rd,(imm+0x800)[31:12] (32-bit wrap-around add) in the accept cycle; if imm[11:0]!=0, SHALL latch rd and imm[11:0], enter EMIT_LO, then push ADDI rd,rd,imm[11:0].
REQ-011 FSM states: IDLE, EMIT_LO; IDLE->EMIT_LO per REQ-010; EMIT_LO->IDLE on the cycle the ADDI is pushed; in EMIT_LO the push SHALL wait while the FIFO is full.
REQ-012 ENC_JAL with imm[0]==1 or any undefined req_op SHALL be consumed, push nothing, and pulse err_invalid the following cycle.
REQ-013 Pushed words SHALL appear on instr/instr_valid one cycle after the push (registered show-ahead FIFO), in push order.
REQ-014 Simultaneous push and pop SHALL leave fifo_count unchanged; read/write pointers SHALL wrap modulo 4.
REQ-015 When fifo_count==0, instr_valid SHALL be 0 and instr SHALL be 0x00000013.
REQ-016 All fields SHALL be masked to their format width; upper req_imm bits not used by the format SHALL be ignored.

Reset
REQ-017 On rst assertion, state SHALL be IDLE and pointers and fifo_count SHALL be 0 immediately, independent of clk.
REQ-018 Reset values: req_ready=0 while rst is high, then 1; instr_valid=0; instr=0x00000013; err_invalid=0; busy=0.
REQ-019 Reset during EMIT_LO or with FIFO entries SHALL drop the pending ADDI and all buffered words.

Structure
REQ-020 enc_op_t, opcode constants, and FIFO_DEPTH SHALL live in the shared rv32 types package beside rv_instr_t.
REQ-021 FIFO SHALL be a sub-module rv32_instr_fifo (parameter DEPTH, 32-bit data, push/pop/full/empty/count); encoding SHALL be combinational logic inside rv32_instr_injector.

Verification
REQ-022 NOP request, instr_ready=1: instr==0x00000013 with instr_valid one cycle after accept.
REQ-023 ADD x3,x1,x2 -> 0x002081B3; SW x2,8(x1) -> 0x0020A423.
REQ-024 LI x5,0x12345FFF: 0x123462B7 then 0xFFF28293; req_ready low in EMIT_LO.
REQ-025 instr_ready=0, five ADDI requests: four accepted, fifo_count==4, req_ready==0; then one pop: count 3, next request accepted, order preserved.
REQ-026 JAL x1,imm=0x3 -> err_invalid pulses once, fifo_count stays 0.
REQ-027 rst asserted mid-LI with FIFO non-empty: all outputs reach reset values before the next clk edge; no ADDI emitted afterwards.
